// File: rtl/elc3_soc_sysid_checker.sv
// Boot-time system-ID checker: reads sysid words 0 and 1 over Avalon-MM and compares them with build-time values.
// Optional macro SYSID_CHECK_CAPTURE_EN keeps the captured_id/captured_ts registers; otherwise those ports are tied low.
module elc3_soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1493141956,
  parameter int unsigned START_DELAY    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int unsigned DLY_W  = 8;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned RTY_W  = 3;
  localparam int unsigned CODE_W = 2;

  localparam logic [DLY_W-1:0] DELAY_LAST = DLY_W'(START_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

  localparam logic [CODE_W-1:0] CODE_OK  = 2'b00;
  localparam logic [CODE_W-1:0] CODE_ID  = 2'b01;
  localparam logic [CODE_W-1:0] CODE_TS  = 2'b10;
  localparam logic [CODE_W-1:0] CODE_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_DELAY,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DLY_W-1:0]   delay_cnt, delay_cnt_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic [RTY_W-1:0]   retry, retry_n;
  logic               read_q, read_n;
  logic               address_q, address_n;
  logic               done_q, done_n;
  logic               pass_q, pass_n;
  logic [CODE_W-1:0]  code_q, code_n;

  // Next state and next registered outputs.
  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    tmo_cnt_n   = tmo_cnt;
    retry_n     = retry;
    read_n      = read_q;
    address_n   = address_q;
    done_n      = done_q;
    pass_n      = pass_q;
    code_n      = code_q;

    unique case (state)
      S_DELAY: begin
        if (delay_cnt == DELAY_LAST) begin
          state_n     = S_RD_ID;
          delay_cnt_n = '0;
          read_n      = 1'b1;
          address_n   = 1'b0;
          retry_n     = '0;
        end else begin
          delay_cnt_n = delay_cnt + DLY_W'(1);
        end
      end

      S_RD_ID: begin
        if (!waitrequest) begin
          state_n   = S_WAIT_ID;
          read_n    = 1'b0;
          tmo_cnt_n = '0;
        end
      end

      S_WAIT_ID: begin
        // Data on the final timeout cycle still counts as a response.
        if (readdatavalid) begin
          if (readdata == EXPECTED_ID) begin
            state_n   = S_RD_TS;
            read_n    = 1'b1;
            address_n = 1'b1;
            retry_n   = '0;
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b0;
            code_n  = CODE_ID;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          if (retry < RTY_MAX) begin
            state_n = S_RD_ID;
            read_n  = 1'b1;
            retry_n = retry + RTY_W'(1);
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b0;
            code_n  = CODE_TMO;
          end
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end

      S_RD_TS: begin
        if (!waitrequest) begin
          state_n   = S_WAIT_TS;
          read_n    = 1'b0;
          tmo_cnt_n = '0;
        end
      end

      S_WAIT_TS: begin
        if (readdatavalid) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          if (readdata == EXPECTED_TS) begin
            pass_n = 1'b1;
            code_n = CODE_OK;
          end else begin
            pass_n = 1'b0;
            code_n = CODE_TS;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          if (retry < RTY_MAX) begin
            state_n = S_RD_TS;
            read_n  = 1'b1;
            retry_n = retry + RTY_W'(1);
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b0;
            code_n  = CODE_TMO;
          end
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end

      S_DONE: begin
        if (start) begin
          state_n     = S_DELAY;
          delay_cnt_n = '0;
          done_n      = 1'b0;
          pass_n      = 1'b0;
          code_n      = CODE_OK;
        end
      end

      default: begin
        state_n     = S_DELAY;
        delay_cnt_n = '0;
        read_n      = 1'b0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_DELAY;
      delay_cnt <= '0;
      tmo_cnt   <= '0;
      retry     <= '0;
      read_q    <= 1'b0;
      address_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      code_q    <= CODE_OK;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
      retry     <= retry_n;
      read_q    <= read_n;
      address_q <= address_n;
      done_q    <= done_n;
      pass_q    <= pass_n;
      code_q    <= code_n;
    end
  end

  assign read      = read_q;
  assign address   = address_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;

`ifdef SYSID_CHECK_CAPTURE_EN
  logic [31:0] cap_id_q;
  logic [31:0] cap_ts_q;

  // Keep whatever word arrived last, matching or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_id_q <= '0;
      cap_ts_q <= '0;
    end else if (readdatavalid) begin
      if (state == S_WAIT_ID) cap_id_q <= readdata;
      if (state == S_WAIT_TS) cap_ts_q <= readdata;
    end
  end

  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;
`else
  assign captured_id = 32'd0;
  assign captured_ts = 32'd0;
`endif

endmodule

// File: doc/elc3_soc_sysid_checker.md
# elc3_soc_sysid_checker

Boot-time Avalon-MM master sitting directly upstream of the system-ID slave in the eLC-3 SoC. After reset it reads the ID word (address 0) and build timestamp word (address 1) and compares both against compile-time expectations. It reports pass/fail to the boot controller and status LEDs, so a bitstream/software mismatch is caught before the LC-3 core is released from hold.

## Interface
- EXPECTED_ID, 32'd0, value required at sysid address 0
- EXPECTED_TS, 32'd1493141956, value required at sysid address 1
- START_DELAY, 16, idle cycles after reset or start before first read (1..255)
- TIMEOUT_CYCLES, 255, max cycles from read issue to readdatavalid (1..65535)
- MAX_RETRIES, 3, extra attempts per word after a timeout (0..7)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; re-runs the check when done=1, ignored otherwise
- address  out  1  Avalon master address (0 = ID, 1 = timestamp)
- read  out  1  Avalon read request
- waitrequest  in  1  slave/interconnect stall
- readdata  in  32  read data
- readdatavalid  in  1  readdata qualifier
- done  out  1  check finished; held until start or reset
- pass  out  1  valid when done=1; both words matched
- fail_code  out  2  00 ok, 01 ID mismatch, 10 timestamp mismatch, 11 timeout
- captured_id  out  32  last ID word received
- captured_ts  out  32  last timestamp word received

## Operation
- States: DELAY, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- DELAY: 8-bit counter counts START_DELAY cycles, then enters RD_ID.
- RD_x: address = 0 (ID) or 1 (TS), read = 1; read and address held stable while waitrequest = 1; the cycle with waitrequest = 0 is the accept; go to WAIT_x and deassert read.
- WAIT_x: 16-bit timeout counter cleared on accept and incremented each cycle. readdatavalid = 1 captures readdata into captured_x and compares it with the expected value:
  - match in WAIT_ID -> RD_TS
  - match in WAIT_TS -> DONE, pass = 1, fail_code = 00
  - mismatch -> DONE, pass = 0, fail_code = 01 (ID) or 10 (TS); no retry on mismatch.
- Timeout: counter reaches TIMEOUT_CYCLES without readdatavalid.
  - If the 3-bit retry count < MAX_RETRIES: increment the count and return to RD_x.
  - Otherwise: DONE, pass = 0, fail_code = 11.
  - The retry count clears on entering each RD_x from a different state.
- readdatavalid outside WAIT_x is ignored.
- readdatavalid on the same cycle the timeout is reached: data wins.
- DONE: outputs hold. start = 1 clears done, pass and fail_code and enters DELAY. Captured registers keep their values until overwritten.
- Reset: every register returns to its reset value in the same cycle, including mid-transaction. The FSM enters DELAY, so any outstanding response arriving later is dropped.

## Timing
- Reset values: read = 0, address = 0, done = 0, pass = 0, fail_code = 00, captured_id = 0, captured_ts = 0; FSM in DELAY with counters = 0.
- First read asserts START_DELAY cycles after the first clock edge with reset low.
- Zero-wait slave with 1-cycle readdatavalid: read high 1 cycle per word.
  - Per-word latency: 1 cycle RD plus 1 cycle WAIT.
  - done rises 4 cycles after read first rises.
- All outputs are registered; nothing combinational from inputs to outputs.

## Configuration
- SYSID_CHECK_CAPTURE_EN:
  - Defined: captured_id and captured_ts are registers updated as described above.
  - Not defined: both ports are tied to 32'd0, and the capture registers are removed. Comparison still uses readdata directly at the valid cycle, so pass/fail behaviour is identical.

## Test plan
- Slave returns 0 at address 0 and 1493141956 at address 1, zero wait, 1-cycle valid -> done = 1, pass = 1, fail_code = 00, done 4 cycles after first read; captured_ts = 1493141956.
- Slave returns 32'h00000005 at address 0 -> done = 1, pass = 0, fail_code = 01, no address-1 read issued; captured_id = 5.
- Timestamp read never gets readdatavalid, MAX_RETRIES = 3, TIMEOUT_CYCLES = 255 -> four address-1 reads, then fail_code = 11.
- waitrequest held high for 10 cycles on the ID read -> read and address stay constant all 10 cycles, then pass = 1. readdatavalid on the exact timeout cycle -> treated as data, no retry.
- Reset asserted during WAIT_TS, and a late readdatavalid arrives 2 cycles after release -> outputs at reset values, the late response is ignored, and a fresh check passes.
- start pulse in DONE -> done drops the next cycle; a second full check completes with pass = 1. start pulse mid-check -> no effect.
